// File: rtl/uart_tx_serializer_pkg.sv
// Shared encodings and line-config payload for the UART transmit serializer.
// The parity feature itself is selected in the top with UART_TX_PARITY_EN.
package uart_tx_serializer_pkg;

  localparam int unsigned UART_FIFO_WIDTH     = 8;
  localparam int unsigned UART_FIFO_COUNTER_W = 5;
  localparam int unsigned STATE_W             = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP1  = 3'd5,
    S_STOP2  = 3'd6
  } tx_state_e;

  typedef enum logic [1:0] {
    DB_5 = 2'b00,
    DB_6 = 2'b01,
    DB_7 = 2'b10,
    DB_8 = 2'b11
  } data_bits_e;

  // Frame shape latched once per frame in POP
  typedef struct packed {
    logic [1:0] data_bits;
    logic       stop2;
  } tx_cfg_t;

  function automatic logic [3:0] num_data_bits(input logic [1:0] code);
    return 4'(code) + 4'd5;
  endfunction

endpackage

// File: rtl/uart_tx_bitclk.sv
// Bit-period timer: counts oversampling ticks and flags the tick that ends a bit.
// i_half shortens the period to half length (second stop of a 1.5-stop frame).
module uart_tx_bitclk #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_half,
  output logic o_bit_done_c
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);

  logic [TICK_W-1:0] r_tick_cnt;
  logic [TICK_W-1:0] w_last;

  assign w_last       = i_half ? HALF_LAST : FULL_LAST;
  assign o_bit_done_c = i_enable && !i_clear && (r_tick_cnt == w_last);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_tick_cnt <= '0;
    end else if (i_enable) begin
      r_tick_cnt <= o_bit_done_c ? '0 : r_tick_cnt + TICK_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops TX FIFO bytes and shifts them out as async frames.
// Define UART_TX_PARITY_EN to build the parity bit; otherwise frames never carry parity.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int unsigned DATA_W     = UART_FIFO_WIDTH,
  parameter int unsigned COUNT_W    = UART_FIFO_COUNTER_W,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [DATA_W-1:0]  tf_data_out,
  input  logic [COUNT_W-1:0] tf_count,
  output logic               tf_pop,
  input  logic [1:0]         data_bits,
  input  logic               stop2,
  input  logic               parity_en,
  input  logic               parity_even,
  input  logic               parity_stick,
  input  logic               tx_break,
  output logic               stx_pad_o,
  output logic [2:0]         tstate,
  output logic               busy
);

  localparam int unsigned BIT_CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  tx_state_e             r_state;
  logic [DATA_W-1:0]     r_shift;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  tx_cfg_t               r_cfg;
  logic                  r_tf_pop;
  logic                  r_busy;
  logic                  r_stx;

  logic                  w_fifo_ne;
  logic                  w_bit_done;
  logic                  w_tick_clear;
  logic                  w_half;
  logic                  w_last_bit;
  logic [BIT_CNT_W-1:0]  w_last_idx;
  logic                  w_level;

  assign w_fifo_ne    = (tf_count != '0);
  assign w_tick_clear = (r_state == S_IDLE) || (r_state == S_POP);
  assign w_half       = (r_state == S_STOP2) && (r_cfg.data_bits == DB_5);
  assign w_last_idx   = BIT_CNT_W'(num_data_bits(r_cfg.data_bits) - 4'd1);
  assign w_last_bit   = (r_bit_cnt == w_last_idx);

  uart_tx_bitclk #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bitclk (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_tick_clear),
    .i_enable     (enable),
    .i_half       (w_half),
    .o_bit_done_c (w_bit_done)
  );

`ifdef UART_TX_PARITY_EN
  logic              r_par_en;
  logic              r_parity;
  logic [DATA_W-1:0] w_mask;
  logic              w_xor;
  logic              w_par_bit;

  // Only the bits actually transmitted contribute to parity
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_mask[i] = (i < int'(num_data_bits(data_bits)));
    end
  end

  assign w_xor     = ^(tf_data_out & w_mask);
  assign w_par_bit = parity_stick ? ~parity_even : (parity_even ? w_xor : ~w_xor);
`else
  logic w_unused_parity;
  assign w_unused_parity = ^{parity_en, parity_even, parity_stick};
`endif

  // Frame FSM; line config and data are captured only in POP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cfg     <= '0;
      r_tf_pop  <= 1'b0;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en  <= 1'b0;
      r_parity  <= 1'b0;
`endif
    end else begin
      r_tf_pop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fifo_ne) begin
            r_state  <= S_POP;
            r_tf_pop <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_POP: begin
          r_shift         <= tf_data_out;
          r_cfg.data_bits <= data_bits;
          r_cfg.stop2     <= stop2;
          r_bit_cnt       <= '0;
`ifdef UART_TX_PARITY_EN
          r_par_en        <= parity_en;
          r_parity        <= w_par_bit;
`endif
          r_state         <= S_START;
        end
        S_START: begin
          if (w_bit_done) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            if (w_last_bit) begin
`ifdef UART_TX_PARITY_EN
              r_state <= r_par_en ? S_PARITY : S_STOP1;
`else
              r_state <= S_STOP1;
`endif
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_done) begin
            r_state <= S_STOP1;
          end
        end
`endif
        S_STOP1: begin
          if (w_bit_done) begin
            if (r_cfg.stop2) begin
              r_state <= S_STOP2;
            end else if (w_fifo_ne) begin
              r_state  <= S_POP;
              r_tf_pop <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_STOP2: begin
          if (w_bit_done) begin
            if (w_fifo_ne) begin
              r_state  <= S_POP;
              r_tf_pop <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Frame line level implied by the current state
  always_comb begin
    w_level = 1'b1;
    case (r_state)
      S_START:  w_level = 1'b0;
      S_DATA:   w_level = r_shift[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_level = r_parity;
`endif
      default:  w_level = 1'b1;
    endcase
  end

  // Break overrides the line without disturbing the frame sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stx <= 1'b1;
    end else begin
      r_stx <= w_level & ~tx_break;
    end
  end

  assign tf_pop    = r_tf_pop;
  assign stx_pad_o = r_stx;
  assign tstate    = r_state;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: FIFO model, line run-length monitor, hand-computed frames.
module tb_uart_tx_serializer;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned COUNT_W = 5;
  localparam logic [2:0]  ST_IDLE = 3'd0;
  localparam logic [2:0]  ST_DATA = 3'd3;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [DATA_W-1:0]  tf_data_out;
  logic [COUNT_W-1:0] tf_count;
  logic               tf_pop;
  logic [1:0]         data_bits;
  logic               stop2;
  logic               parity_en;
  logic               parity_even;
  logic               parity_stick;
  logic               tx_break;
  logic               stx_pad_o;
  logic [2:0]         tstate;
  logic               busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] fifo_mem [16];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   pops = 0;
  int   underflows = 0;
  int   run_len_q[$];
  logic run_lvl_q[$];
  logic en_on = 1'b1;
  int   base;
  int   p0;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .DATA_W     (DATA_W),
    .COUNT_W    (COUNT_W),
    .OVERSAMPLE (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .tf_data_out  (tf_data_out),
    .tf_count     (tf_count),
    .tf_pop       (tf_pop),
    .data_bits    (data_bits),
    .stop2        (stop2),
    .parity_en    (parity_en),
    .parity_even  (parity_even),
    .parity_stick (parity_stick),
    .tx_break     (tx_break),
    .stx_pad_o    (stx_pad_o),
    .tstate       (tstate),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // 16x tick every 4 clocks -> one bit = 64 clocks
  initial begin
    int div;
    div = 0;
    enable = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % 4;
      enable = en_on && (div == 0);
    end
  end

  // FIFO model: a pop seen in one cycle retires the head after the next edge
  initial begin
    logic pop_seen;
    tf_count = '0;
    tf_data_out = '0;
    forever begin
      @(negedge clk);
      pop_seen = tf_pop;
      @(posedge clk);
      #1;
      if (pop_seen) begin
        if (wr_ptr == rd_ptr) underflows++;
        else begin
          rd_ptr++;
          pops++;
        end
      end
      tf_count    = COUNT_W'(wr_ptr - rd_ptr);
      tf_data_out = fifo_mem[rd_ptr % 16];
    end
  end

  // Line monitor: records each completed constant-level run in clocks
  initial begin
    logic prev;
    int   len;
    prev = 1'b1;
    len  = 0;
    forever begin
      @(negedge clk);
      if (stx_pad_o !== prev) begin
        run_lvl_q.push_back(prev);
        run_len_q.push_back(len);
        prev = stx_pad_o;
        len  = 1;
      end else begin
        len++;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    fifo_mem[wr_ptr % 16] = b;
    wr_ptr++;
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic s2, input logic pe,
                         input logic ev, input logic st);
    @(negedge clk);
    data_bits = db; stop2 = s2; parity_en = pe; parity_even = ev; parity_stick = st;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 20000 && !done; t++) begin
      @(negedge clk);
      if (wr_ptr == rd_ptr && !busy) done = 1'b1;
    end
    check_eq(tag, 32'(done), 32'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(negedge clk);
      if (tstate == s) done = 1'b1;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_run(input string tag, input int idx, input logic lvl, input int len);
    int   l;
    logic v;
    l = (idx < run_len_q.size()) ? run_len_q[idx] : -1;
    v = (idx < run_lvl_q.size()) ? run_lvl_q[idx] : 1'bx;
    check_eq({tag, "_lvl"}, 32'(v), 32'(lvl));
    check_eq({tag, "_len"}, l, len);
  endtask

  task automatic chk_start(input string tag, input int idx, input int extra);
    int l;
    l = (idx < run_len_q.size()) ? run_len_q[idx] - extra : -1;
    check_eq(tag, 32'(l >= 61 && l <= 64), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    data_bits = 2'b11; stop2 = 1'b0; parity_en = 1'b0; parity_even = 1'b0;
    parity_stick = 1'b0; tx_break = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_stx",   32'(stx_pad_o), 32'd1);
    check_eq("reset_busy",  32'(busy),      32'd0);
    check_eq("reset_state", 32'(tstate),    32'(ST_IDLE));
    check_eq("reset_pop",   32'(tf_pop),    32'd0);

    // Reset in the middle of the data bits of 0xA5
    push(8'hA5);
    wait_state("rstmid_reach_data", ST_DATA);
    repeat (100) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rstmid_stx",   32'(stx_pad_o), 32'd1);
    check_eq("rstmid_busy",  32'(busy),      32'd0);
    check_eq("rstmid_state", 32'(tstate),    32'(ST_IDLE));
    check_eq("rstmid_pop",   32'(tf_pop),    32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rstmid_pops",  pops,           1);
    check_eq("rstmid_stays", 32'(tstate),    32'(ST_IDLE));

    // 8N1 0x55: start, 1,0,1,0,1,0,1,0, stop
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    base = run_len_q.size(); p0 = pops;
    push(8'h55);
    wait_idle("f55_done");
    check_eq("f55_pops", pops - p0, 1);
    check_eq("f55_runs", run_len_q.size() - base, 10);
    chk_start("f55_start", base + 1, 0);
    for (int i = 2; i <= 9; i++) chk_run($sformatf("f55_bit%0d", i - 2), base + i, (i % 2) == 0, 64);
    check_eq("f55_idle", 32'(tstate), 32'(ST_IDLE));

    // 7E1 0x41: data 1000001, parity 0 when built with parity
    set_cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    base = run_len_q.size();
    push(8'h41);
    wait_idle("f41_done");
    chk_run("f41_d0",   base + 2, 1'b1, 64);
    chk_run("f41_d1_5", base + 3, 1'b0, 320);
`ifdef UART_TX_PARITY_EN
    check_eq("f41_runs", run_len_q.size() - base, 6);
    chk_run("f41_d6",   base + 4, 1'b1, 64);
    chk_run("f41_par",  base + 5, 1'b0, 64);
`else
    check_eq("f41_runs", run_len_q.size() - base, 4);
`endif

    // 8O1 0x00 twice: parity 1 merges with stop -> high run 129 (65 without parity)
    set_cfg(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    base = run_len_q.size(); p0 = pops;
    push(8'h00); push(8'h00);
    wait_idle("f8o1_done");
    check_eq("f8o1_pops", pops - p0, 2);
    check_eq("f8o1_runs", run_len_q.size() - base, 4);
    chk_start("f8o1_start", base + 1, 512);
`ifdef UART_TX_PARITY_EN
    chk_run("f8o1_par_stop", base + 2, 1'b1, 129);
`else
    chk_run("f8o1_par_stop", base + 2, 1'b1, 65);
`endif
    chk_run("f8o1_second", base + 3, 1'b0, 575);

    // 5 data bits, stop2: 1.5 stop = 24 ticks
    set_cfg(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    base = run_len_q.size();
    push(8'h00); push(8'h00);
    wait_idle("f5s2_done");
    chk_run("f5s2_stop",   base + 2, 1'b1, 97);
    chk_run("f5s2_second", base + 3, 1'b0, 383);

    // 8 data bits, stop2: 32 ticks
    set_cfg(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    base = run_len_q.size();
    push(8'h00); push(8'h00);
    wait_idle("f8s2_done");
    chk_run("f8s2_stop", base + 2, 1'b1, 129);

    // Three frames back-to-back
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    base = run_len_q.size(); p0 = pops;
    push(8'h00); push(8'h00); push(8'h00);
    wait_idle("b2b_done");
    check_eq("b2b_pops", pops - p0, 3);
    check_eq("b2b_runs", run_len_q.size() - base, 6);
    chk_run("b2b_stop1", base + 2, 1'b1, 65);
    chk_run("b2b_f2",    base + 3, 1'b0, 575);
    chk_run("b2b_stop2", base + 4, 1'b1, 65);
    chk_run("b2b_f3",    base + 5, 1'b0, 575);

    // Ticks withheld mid-frame: FSM holds
    p0 = pops;
    push(8'hFF);
    wait_state("hold_reach_data", ST_DATA);
    repeat (20) @(negedge clk);
    en_on = 1'b0;
    repeat (200) @(negedge clk);
    check_eq("hold_state", 32'(tstate),    32'(ST_DATA));
    check_eq("hold_line",  32'(stx_pad_o), 32'd1);
    check_eq("hold_busy",  32'(busy),      32'd1);
    en_on = 1'b1;
    wait_idle("hold_done");
    check_eq("hold_pops", pops - p0, 1);

    // Break forces the line low for a whole frame
    @(negedge clk); tx_break = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("brk_low", 32'(stx_pad_o), 32'd0);
    base = run_len_q.size(); p0 = pops;
    push(8'h55);
    wait_idle("brk_done");
    check_eq("brk_runs",  run_len_q.size() - base, 0);
    check_eq("brk_pops",  pops - p0, 1);
    check_eq("brk_state", 32'(tstate), 32'(ST_IDLE));
    tx_break = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("brk_release", 32'(stx_pad_o), 32'd1);
    check_eq("no_underflow", underflows, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
